opcode_injector: RTL and testbench

// - Write-side counterpart of the M1 opcode decoder: on a trap request, supplies a forced

---
 rtl/opcode_injector_pkg.sv | 45 ++++
 rtl/opcode_injector_if.sv | 32 +++
 rtl/opcode_injector_bus_edge_sync.sv | 38 +++
 rtl/opcode_injector.sv | 126 ++++++++++++
 tb/tb_opcode_injector.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/opcode_injector_pkg.sv
// Shared definitions for the trap opcode injector: Z80 opcodes,
// strobe bit positions and injector state encodings.
package opcode_injector_pkg;

   localparam logic [7:0] OP_CALL   = 8'hCD;
   localparam logic [7:0] OP_PFX_CB = 8'hCB;
   localparam logic [7:0] OP_PFX_ED = 8'hED;
   localparam logic [7:0] OP_PFX_DD = 8'hDD;
   localparam logic [7:0] OP_PFX_FD = 8'hFD;

   localparam int BIT_RD   = 0;
   localparam int BIT_MREQ = 1;
   localparam int BIT_M1   = 2;
   localparam int NSTROBE  = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_OPC   = 3'd2,
      ST_GAP1  = 3'd3,
      ST_LO    = 3'd4,
      ST_GAP2  = 3'd5,
      ST_HI    = 3'd6,
      ST_DONE  = 3'd7
   } inj_state_e;

   function automatic logic inj_drive(inj_state_e st);
      return (st == ST_OPC) || (st == ST_LO) || (st == ST_HI);
   endfunction

   // Byte forced onto the bus; zero outside the three injected reads.
   function automatic logic [7:0] inj_byte(inj_state_e st,
                                           logic [15:0] vec);
      logic [7:0] b;
      b = 8'h00;
      case (st)
         ST_OPC:  b = OP_CALL;
         ST_LO:   b = vec[7:0];
         ST_HI:   b = vec[15:8];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/opcode_injector_if.sv
// Z80 bus strobes, trap request/ack and injected-data signals
// between the CPU side (master) and the injector (slave).
interface opcode_injector_if;

   logic        m1_n;
   logic        mreq_n;
   logic        rd_n;
   logic        at_isr_end;
   logic        trap_req;
   logic [15:0] trap_vec;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        mem_inhibit;
   logic        trap_ack;
   logic        trap_err;
   logic        busy;

   modport master (
      output m1_n, mreq_n, rd_n,
      output at_isr_end, trap_req, trap_vec,
      input  data_out, data_oe, mem_inhibit,
      input  trap_ack, trap_err, busy
   );

   modport slave (
      input  m1_n, mreq_n, rd_n,
      input  at_isr_end, trap_req, trap_vec,
      output data_out, data_oe, mem_inhibit,
      output trap_ack, trap_err, busy
   );

endinterface

// File: rtl/opcode_injector_bus_edge_sync.sv
// Multi-bit strobe synchronizer with rise/fall detection on the
// synchronized copy. Reset value models idle (high) strobes.
module bus_edge_sync #(
   parameter int             W           = 3,
   parameter int             SYNC_STAGES = 2,
   parameter logic [W-1:0]   RST_VAL     = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] lvl_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);

   logic [W-1:0] sync_q [SYNC_STAGES];
   logic [W-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= RST_VAL;
         end
         prev_q <= RST_VAL;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign lvl_o  = sync_q[SYNC_STAGES-1];
   assign rise_o = lvl_o & ~prev_q;
   assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/opcode_injector.sv
// Forces CALL nn onto the Z80 bus at the next instruction boundary
// when a trap is requested, inhibiting RAM/ROM during those reads.
module opcode_injector
   import opcode_injector_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   opcode_injector_if.slave   bus
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   inj_state_e   state_q, state_d;
   logic [15:0]  vec_q, vec_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         err_q, err_d;

   logic [NSTROBE-1:0] lvl, rise, fall;
   logic               rd_fall, rd_rise, m1;
   logic               gap, tmo;

   bus_edge_sync #(
      .W           (NSTROBE),
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     ('1)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    ({bus.m1_n, bus.mreq_n, bus.rd_n}),
      .lvl_o  (lvl),
      .rise_o (rise),
      .fall_o (fall)
   );

   // Interrupt-ack has MREQ high, so gating with MREQ excludes it.
   assign rd_fall = fall[BIT_RD] & ~lvl[BIT_MREQ];
   assign rd_rise = rise[BIT_RD];
   assign m1      = ~lvl[BIT_M1];

   assign gap = (state_q == ST_GAP1) || (state_q == ST_GAP2);
   assign tmo = gap && (cnt_q == TMO_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= 16'h0000;
         cnt_q   <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.trap_req) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!bus.trap_req) begin
               state_d = ST_IDLE;
            end else if (rd_fall && m1 && bus.at_isr_end) begin
               state_d = ST_OPC;
               vec_d   = bus.trap_vec;
            end
         end
         ST_OPC: begin
            if (rd_rise) state_d = ST_GAP1;
         end
         ST_GAP1: begin
            if (rd_fall && !m1) begin
               state_d = ST_LO;
            end else if (tmo) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_LO: begin
            if (rd_rise) state_d = ST_GAP2;
         end
         ST_GAP2: begin
            if (rd_fall && !m1) begin
               state_d = ST_HI;
            end else if (tmo) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_HI: begin
            if (rd_rise) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = 8'h00;
      end else if (gap) begin
         cnt_d = cnt_q + 8'h01;
      end
   end

   assign bus.data_oe     = inj_drive(state_q);
   assign bus.mem_inhibit = inj_drive(state_q);
   assign bus.data_out    = inj_byte(state_q, vec_q);
   assign bus.trap_ack    = (state_q == ST_DONE);
   assign bus.trap_err    = err_q;
   assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_opcode_injector.sv
// Scoreboard bench: stimulus queues expected injected bytes, a
// negedge monitor pops them on each data_oe rise and checks them.
module tb_opcode_injector;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   opcode_injector_if bus();

   opcode_injector #(
      .SYNC_STAGES (2),
      .TIMEOUT_CYC (255)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int ack_cnt  = 0;
   int err_cnt  = 0;
   logic [7:0] exp_q[$];
   logic oe_prev = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.trap_ack) ack_cnt++;
      if (bus.trap_err) err_cnt++;
      if (bus.data_oe && !oe_prev) begin
         chk("drive_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("inj_byte", bus.data_out, exp_q.pop_front());
      end
      chk("inhibit_eq_oe", bus.mem_inhibit, bus.data_oe);
      if (!bus.data_oe) chk("idle_data_zero", bus.data_out, 0);
      oe_prev = bus.data_oe;
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m1_fetch();
      bus.m1_n = 1'b0;
      cyc(2);
      bus.mreq_n = 1'b0;
      bus.rd_n = 1'b0;
      cyc(8);
      bus.rd_n = 1'b1;
      bus.mreq_n = 1'b1;
      bus.m1_n = 1'b1;
      cyc(2);
      bus.mreq_n = 1'b0;
      cyc(4);
      bus.mreq_n = 1'b1;
      cyc(6);
   endtask

   task automatic mem_read(bit drop);
      bus.mreq_n = 1'b0;
      bus.rd_n = 1'b0;
      cyc(5);
      if (drop) bus.trap_req = 1'b0;
      cyc(3);
      bus.rd_n = 1'b1;
      bus.mreq_n = 1'b1;
      cyc(6);
   endtask

   // RD pulsed with MREQ high so only the MREQ gate rejects it.
   task automatic int_ack();
      bus.m1_n = 1'b0;
      cyc(2);
      bus.rd_n = 1'b0;
      cyc(4);
      bus.rd_n = 1'b1;
      bus.m1_n = 1'b1;
      cyc(6);
   endtask

   task automatic refresh();
      bus.mreq_n = 1'b0;
      cyc(4);
      bus.mreq_n = 1'b1;
      cyc(4);
   endtask

   initial begin
      int n;
      bit seen;
      bus.m1_n = 1'b1;
      bus.mreq_n = 1'b1;
      bus.rd_n = 1'b1;
      bus.at_isr_end = 1'b1;
      bus.trap_req = 1'b0;
      bus.trap_vec = 16'h0000;
      cyc(4);
      chk("reset_outputs",
          {bus.data_out, bus.data_oe, bus.mem_inhibit,
           bus.trap_ack, bus.trap_err, bus.busy}, 0);
      rst_n = 1'b1;
      cyc(3);

      // no trap pending: plain fetch untouched
      m1_fetch();
      chk("idle_busy", bus.busy, 0);

      // basic CALL 1234 with latency and ack-width checks
      bus.trap_vec = 16'h1234;
      bus.trap_req = 1'b1;
      cyc(3);
      chk("armed_busy", bus.busy, 1);
      exp_q.push_back(8'hCD);
      m1_fetch();
      exp_q.push_back(8'h34);
      mem_read(0);
      exp_q.push_back(8'h12);
      bus.mreq_n = 1'b0;
      bus.rd_n = 1'b0;
      cyc(2);
      chk("oe_lat_early", bus.data_oe, 0);
      cyc(1);
      chk("oe_lat_rise", bus.data_oe, 1);
      cyc(5);
      bus.rd_n = 1'b1;
      bus.mreq_n = 1'b1;
      cyc(2);
      chk("oe_hold", bus.data_oe, 1);
      cyc(1);
      chk("oe_drop", bus.data_oe, 0);
      chk("ack_pulse", bus.trap_ack, 1);
      cyc(1);
      chk("ack_width", bus.trap_ack, 0);
      cyc(4);
      bus.trap_req = 1'b0;
      cyc(4);
      chk("ack_count_basic", ack_cnt, 1);

      // prefix pending on first fetch, boundary on second
      bus.trap_vec = 16'hABCD;
      bus.at_isr_end = 1'b0;
      bus.trap_req = 1'b1;
      cyc(3);
      m1_fetch();
      bus.at_isr_end = 1'b1;
      exp_q.push_back(8'hCD);
      m1_fetch();
      exp_q.push_back(8'hCD);
      mem_read(0);
      exp_q.push_back(8'hAB);
      mem_read(0);
      bus.trap_req = 1'b0;
      cyc(4);
      chk("ack_count_prefix", ack_cnt, 2);

      // cancel while armed
      bus.trap_vec = 16'h7777;
      bus.trap_req = 1'b1;
      cyc(5);
      bus.trap_req = 1'b0;
      cyc(3);
      m1_fetch();
      chk("cancel_busy", bus.busy, 0);
      chk("ack_count_cancel", ack_cnt, 2);

      // request dropped during LO: sequence still completes
      bus.trap_vec = 16'h5A3C;
      bus.trap_req = 1'b1;
      cyc(3);
      exp_q.push_back(8'hCD);
      m1_fetch();
      exp_q.push_back(8'h3C);
      mem_read(1);
      exp_q.push_back(8'h5A);
      mem_read(0);
      cyc(4);
      chk("ack_count_drop", ack_cnt, 3);
      chk("drop_busy", bus.busy, 0);

      // interrupt-ack and refresh cycles interleaved
      bus.trap_vec = 16'h0F0E;
      bus.trap_req = 1'b1;
      cyc(3);
      int_ack();
      exp_q.push_back(8'hCD);
      m1_fetch();
      int_ack();
      refresh();
      exp_q.push_back(8'h0E);
      mem_read(0);
      refresh();
      int_ack();
      exp_q.push_back(8'h0F);
      mem_read(0);
      bus.trap_req = 1'b0;
      cyc(4);
      chk("ack_count_ignore", ack_cnt, 4);

      // timeout in GAP1
      bus.trap_vec = 16'h1111;
      bus.trap_req = 1'b1;
      cyc(3);
      exp_q.push_back(8'hCD);
      m1_fetch();
      n = 0;
      seen = 1'b0;
      while (n < 400 && !seen) begin
         @(negedge clk);
         n++;
         if (bus.trap_err) begin
            seen = 1'b1;
            chk("tmo_busy", bus.busy, 0);
            chk("tmo_oe", bus.data_oe, 0);
         end
      end
      chk("tmo_seen", 32'(seen), 1);
      chk("tmo_window", 32'(n >= 235 && n <= 260), 1);
      #1;
      bus.trap_req = 1'b0;
      cyc(4);
      chk("err_count", err_cnt, 1);
      chk("ack_count_tmo", ack_cnt, 4);
      chk("tmo_idle", bus.busy, 0);

      // reset during HI
      bus.trap_vec = 16'hBEEF;
      bus.trap_req = 1'b1;
      cyc(3);
      exp_q.push_back(8'hCD);
      m1_fetch();
      exp_q.push_back(8'hEF);
      mem_read(0);
      exp_q.push_back(8'hBE);
      bus.mreq_n = 1'b0;
      bus.rd_n = 1'b0;
      cyc(5);
      chk("hi_driving", bus.data_oe, 1);
      rst_n = 1'b0;
      cyc(1);
      chk("rst_oe", bus.data_oe, 0);
      chk("rst_inhibit", bus.mem_inhibit, 0);
      chk("rst_busy", bus.busy, 0);
      bus.rd_n = 1'b1;
      bus.mreq_n = 1'b1;
      bus.trap_req = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(8);
      chk("ack_count_rst", ack_cnt, 4);
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
